falu_cmp_result_queue: RTL

Result buffer that sits directly downstream of the FALU compare unit (FEQ/FLT/FLE/FMIN/FMAX) and upstream of the common-data-bus writeback arbiter. It captures each compare result with its ROB tag, destination register and exception flag, and converts the compare unit's single invalid indication into a RISC-V fflags vector. It then holds results in a small in-order FIFO until the CDB grants a writeback slot, so the combinational compare path never stalls on writeback contention.

---
 rtl/falu_cmp_result_queue.sv | 70 +++++++
 1 files changed

// File: rtl/falu_cmp_result_queue.sv
// falu_cmp_result_queue: in-order result FIFO between the FALU compare unit and CDB writeback
module falu_cmp_result_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int RD_W  = 6
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [63:0]              IN_RESULT,
  input  logic                     IN_INVALID,
  input  logic [TAG_W-1:0]         IN_TAG,
  input  logic [RD_W-1:0]          IN_RD,
  input  logic                     IN_IS_FPR,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [63:0]              OUT_RESULT,
  output logic [4:0]               OUT_FFLAGS,
  output logic [TAG_W-1:0]         OUT_TAG,
  output logic [RD_W-1:0]          OUT_RD,
  output logic                     OUT_IS_FPR,
  output logic [$clog2(DEPTH):0]   COUNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [63:0]      result;
    logic             nv;
    logic [TAG_W-1:0] tag;
    logic [RD_W-1:0]  rd;
    logic             is_fpr;
  } entry_t;
  entry_t          mem [DEPTH];
  logic [CW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  entry_t          head;
  // The extra pointer bit makes wr_ptr - rd_ptr the exact occupancy, including full
  assign COUNT     = wr_ptr - rd_ptr;
  assign IN_READY  = COUNT != CW'(DEPTH);
  assign OUT_VALID = COUNT != '0;
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !FLUSH) begin
      mem[wr_ptr[AW-1:0]] <= '{result: IN_RESULT, nv: IN_INVALID, tag: IN_TAG, rd: IN_RD, is_fpr: IN_IS_FPR};
    end
  end
  assign head       = mem[rd_ptr[AW-1:0]];
  assign OUT_RESULT = head.result;
  assign OUT_FFLAGS = {head.nv, 4'b0000};
  assign OUT_TAG    = head.tag;
  assign OUT_RD     = head.rd;
  assign OUT_IS_FPR = head.is_fpr;
endmodule
